control_sequencer: RTL and testbench

//  Hardwired control unit that drives the DataPath strobes.

---
 rtl/control_sequencer_pkg.sv | 90 +++++++++
 rtl/control_sequencer_if.sv | 33 +++
 rtl/control_sequencer_instr_decoder.sv | 32 +++
 rtl/control_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the hardwired control sequencer.
// Holds the state encoding, opcode and ALU code tables, and the strobe bundle.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CL_BINARY  = 3'd0,
    CL_WIDE    = 3'd1,
    CL_UNARY   = 3'd2,
    CL_NOP     = 3'd3,
    CL_HALT    = 3'd4,
    CL_ILLEGAL = 3'd5
  } op_class_e;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01001;
  localparam logic [4:0] OPC_ROR  = 5'b01010;
  localparam logic [4:0] OPC_ROL  = 5'b01011;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [7:0] ALU_NONE = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_AND  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h03;
  localparam logic [7:0] ALU_SUB  = 8'h04;
  localparam logic [7:0] ALU_MUL  = 8'h05;
  localparam logic [7:0] ALU_DIV  = 8'h06;
  localparam logic [7:0] ALU_SHR  = 8'h07;
  localparam logic [7:0] ALU_SHL  = 8'h08;
  localparam logic [7:0] ALU_ROR  = 8'h09;
  localparam logic [7:0] ALU_ROL  = 8'h0A;
  localparam logic [7:0] ALU_NEG  = 8'h0B;
  localparam logic [7:0] ALU_NOT  = 8'h0C;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic hi_in;
    logic lo_in;
    logic r_in;
    logic r_out;
  } strobes_t;

  function automatic logic [4:0] ir_opc(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  // Register field n (0=Ra, 1=Rb, 2=Rc) sits in consecutive nibbles below the opcode.
  function automatic logic [3:0] ir_reg(input logic [31:0] ir, input logic [1:0] n);
    logic [3:0] f;
    case (n)
      2'd0:    f = ir[26:23];
      2'd1:    f = ir[22:19];
      2'd2:    f = ir[18:15];
      default: f = 4'd0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer (master) and the DataPath (slave).
interface control_sequencer_if #(
  parameter int COUNT_W    = 16,
  parameter int ALU_CTRL_W = 8
);
  logic                  run;
  logic                  mem_ready;
  logic [31:0]           ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
  logic read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic                  Rin;
  logic                  Rout;
  logic [3:0]            reg_sel;
  logic [ALU_CTRL_W-1:0] ALU_control;
  logic                  halted;
  logic                  illegal_op;
  logic [COUNT_W-1:0]    instr_count;
  logic [3:0]            state_out;

  modport master (
    input  run, mem_ready, ir,
    output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
    output read, MDRin, MDRout, IRin, Yin, HIin, LOin,
    output Rin, Rout, reg_sel, ALU_control, halted, illegal_op, instr_count, state_out
  );

  modport slave (
    output run, mem_ready, ir,
    input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
    input  read, MDRin, MDRout, IRin, Yin, HIin, LOin,
    input  Rin, Rout, reg_sel, ALU_control, halted, illegal_op, instr_count, state_out
  );
endinterface

// File: rtl/control_sequencer_instr_decoder.sv
// Combinational opcode decoder: classifies the opcode and looks up its ALU code.
module instr_decoder
  import control_sequencer_pkg::*;
(
  input  logic [4:0] opc,
  output op_class_e  op_class,
  output logic [7:0] alu_code
);

  always_comb begin
    op_class = CL_ILLEGAL;
    alu_code = ALU_NONE;
    case (opc)
      OPC_ADD:  begin op_class = CL_BINARY; alu_code = ALU_ADD; end
      OPC_SUB:  begin op_class = CL_BINARY; alu_code = ALU_SUB; end
      OPC_AND:  begin op_class = CL_BINARY; alu_code = ALU_AND; end
      OPC_OR:   begin op_class = CL_BINARY; alu_code = ALU_OR;  end
      OPC_SHR:  begin op_class = CL_BINARY; alu_code = ALU_SHR; end
      OPC_SHL:  begin op_class = CL_BINARY; alu_code = ALU_SHL; end
      OPC_ROR:  begin op_class = CL_BINARY; alu_code = ALU_ROR; end
      OPC_ROL:  begin op_class = CL_BINARY; alu_code = ALU_ROL; end
      OPC_MUL:  begin op_class = CL_WIDE;   alu_code = ALU_MUL; end
      OPC_DIV:  begin op_class = CL_WIDE;   alu_code = ALU_DIV; end
      OPC_NEG:  begin op_class = CL_UNARY;  alu_code = ALU_NEG; end
      OPC_NOT:  begin op_class = CL_UNARY;  alu_code = ALU_NOT; end
      OPC_NOP:  begin op_class = CL_NOP;    alu_code = ALU_NONE; end
      OPC_HALT: begin op_class = CL_HALT;   alu_code = ALU_NONE; end
      default:  begin op_class = CL_ILLEGAL; alu_code = ALU_NONE; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, decode T3, register-register execute T3-T6.
// Build option CU_ILLEGAL_TRAP_EN traps undefined opcodes into HALT with illegal_op set.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int ALU_CTRL_W = 8
) (
  input  logic clock,
  input  logic clear_n,
  control_sequencer_if.master bus
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  op_class_e          op_class_s;
  logic [7:0]         alu_code_s;
  logic [3:0]         ra_s, rb_s, rc_s;
  logic               wide_s;
  logic               end_s;
  strobes_t           strb_s;
  logic [3:0]         reg_sel_s;
  logic [7:0]         alu_s;
  logic               unused_ir_s;

  assign ra_s        = ir_reg(bus.ir, 2'd0);
  assign rb_s        = ir_reg(bus.ir, 2'd1);
  assign rc_s        = ir_reg(bus.ir, 2'd2);
  assign wide_s      = (op_class_s == CL_WIDE);
  assign unused_ir_s = ^bus.ir[14:0];

  instr_decoder u_dec (
    .opc      (ir_opc(bus.ir)),
    .op_class (op_class_s),
    .alu_code (alu_code_s)
  );

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Next state; end_s marks the retiring edge where the counter bumps and run is re-sampled.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    end_s   = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_T0;
        else         state_d = ST_IDLE;
      end
      ST_T0: state_d = ST_T1;
      ST_T1: begin
        if (bus.mem_ready) state_d = ST_T2;
        else               state_d = ST_T1;
      end
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        case (op_class_s)
          CL_BINARY, CL_WIDE: state_d = ST_T4;
          CL_UNARY:           state_d = ST_T5;
          CL_NOP:             end_s   = 1'b1;
          CL_HALT: begin
            state_d = ST_HALT;
            count_d = count_q + COUNT_W'(1);
          end
          CL_ILLEGAL: begin
`ifdef CU_ILLEGAL_TRAP_EN
            state_d   = ST_HALT;
            illegal_d = 1'b1;
`else
            end_s = 1'b1;
`endif
          end
          default: end_s = 1'b1;
        endcase
      end
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        if (wide_s) state_d = ST_T6;
        else        end_s   = 1'b1;
      end
      ST_T6:   end_s   = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (end_s) begin
      count_d = count_q + COUNT_W'(1);
      state_d = bus.run ? ST_T0 : ST_IDLE;
    end else begin
      count_d = count_d;
    end
  end

  // State, retired-instruction counter and trap flag.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      count_q <= {COUNT_W{1'b0}};
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Moore strobe decode: exactly one bus driver per state, selects zeroed when unused.
  always_comb begin
    strb_s    = strobes_t'(16'h0000);
    reg_sel_s = 4'd0;
    alu_s     = ALU_NONE;
    case (state_q)
      ST_T0: begin
        strb_s.pc_out = 1'b1;
        strb_s.mar_in = 1'b1;
        strb_s.inc_pc = 1'b1;
        strb_s.z_in   = 1'b1;
      end
      ST_T1: begin
        strb_s.zlow_out = 1'b1;
        strb_s.pc_in    = 1'b1;
        strb_s.read     = 1'b1;
        strb_s.mdr_in   = 1'b1;
      end
      ST_T2: begin
        strb_s.mdr_out = 1'b1;
        strb_s.ir_in   = 1'b1;
      end
      ST_T3: begin
        if (op_class_s == CL_BINARY || op_class_s == CL_WIDE) begin
          strb_s.r_out = 1'b1;
          strb_s.y_in  = 1'b1;
          reg_sel_s    = rb_s;
        end else if (op_class_s == CL_UNARY) begin
          strb_s.r_out = 1'b1;
          strb_s.z_in  = 1'b1;
          reg_sel_s    = rb_s;
          alu_s        = alu_code_s;
        end else begin
          reg_sel_s = 4'd0;
        end
      end
      ST_T4: begin
        strb_s.r_out = 1'b1;
        strb_s.z_in  = 1'b1;
        reg_sel_s    = rc_s;
        alu_s        = alu_code_s;
      end
      ST_T5: begin
        strb_s.zlow_out = 1'b1;
        if (wide_s) begin
          strb_s.lo_in = 1'b1;
        end else begin
          strb_s.r_in = 1'b1;
          reg_sel_s   = ra_s;
        end
      end
      ST_T6: begin
        strb_s.zhigh_out = 1'b1;
        strb_s.hi_in     = 1'b1;
      end
      default: strb_s = strobes_t'(16'h0000);
    endcase
  end

  assign bus.PCout       = strb_s.pc_out;
  assign bus.MARin       = strb_s.mar_in;
  assign bus.IncPC       = strb_s.inc_pc;
  assign bus.Zin         = strb_s.z_in;
  assign bus.Zlowout     = strb_s.zlow_out;
  assign bus.Zhighout    = strb_s.zhigh_out;
  assign bus.PCin        = strb_s.pc_in;
  assign bus.read        = strb_s.read;
  assign bus.MDRin       = strb_s.mdr_in;
  assign bus.MDRout      = strb_s.mdr_out;
  assign bus.IRin        = strb_s.ir_in;
  assign bus.Yin         = strb_s.y_in;
  assign bus.HIin        = strb_s.hi_in;
  assign bus.LOin        = strb_s.lo_in;
  assign bus.Rin         = strb_s.r_in;
  assign bus.Rout        = strb_s.r_out;
  assign bus.reg_sel     = reg_sel_s;
  assign bus.ALU_control = ALU_CTRL_W'(alu_s);
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.instr_count = count_q;
  assign bus.state_out   = state_q;
`ifdef CU_ILLEGAL_TRAP_EN
  assign bus.illegal_op  = illegal_q;
`else
  assign bus.illegal_op  = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle strobe checks against a micro-op table model.
module tb_control_sequencer;

  logic clock;
  logic clear_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_cnt = 0;

  control_sequencer_if #(.COUNT_W(16), .ALU_CTRL_W(8)) cs_if ();

  control_sequencer #(.COUNT_W(16), .ALU_CTRL_W(8)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (cs_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [17:0] S_PCOUT = 18'h20000, S_MARIN = 18'h10000, S_INCPC = 18'h08000;
  localparam logic [17:0] S_ZIN   = 18'h04000, S_ZLOW  = 18'h02000, S_ZHIGH = 18'h01000;
  localparam logic [17:0] S_PCIN  = 18'h00800, S_READ  = 18'h00400, S_MDRIN = 18'h00200;
  localparam logic [17:0] S_MDROUT= 18'h00100, S_IRIN  = 18'h00080, S_YIN   = 18'h00040;
  localparam logic [17:0] S_HIIN  = 18'h00020, S_LOIN  = 18'h00010, S_RIN   = 18'h00008;
  localparam logic [17:0] S_ROUT  = 18'h00004, S_HALT  = 18'h00002, S_ILL   = 18'h00001;

  localparam int K_BIN = 0, K_WIDE = 1, K_UN = 2, K_NOP = 3, K_HALT = 4, K_TRAP = 5;

  typedef struct {
    logic [17:0] strb;
    logic [3:0]  sel;
    logic [7:0]  alu;
    bit          alu_chk;
    bit          mem;
    int          phase;
  } ph_t;

  function automatic logic [17:0] obs_strb();
    return {cs_if.PCout, cs_if.MARin, cs_if.IncPC, cs_if.Zin, cs_if.Zlowout, cs_if.Zhighout,
            cs_if.PCin, cs_if.read, cs_if.MDRin, cs_if.MDRout, cs_if.IRin, cs_if.Yin,
            cs_if.HIin, cs_if.LOin, cs_if.Rin, cs_if.Rout, cs_if.halted, cs_if.illegal_op};
  endfunction

  function automatic int kind_of(input logic [4:0] opc);
    case (opc)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01001, 5'b01010, 5'b01011: return K_BIN;
      5'b01111, 5'b10000:           return K_WIDE;
      5'b10001, 5'b10010:           return K_UN;
      5'b11010:                     return K_NOP;
      5'b11011:                     return K_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
      default:                      return K_TRAP;
`else
      default:                      return K_NOP;
`endif
    endcase
  endfunction

  function automatic logic [7:0] alu_of(input logic [4:0] opc);
    case (opc)
      5'b00011: return 8'h01;  5'b00101: return 8'h02;  5'b00110: return 8'h03;
      5'b00100: return 8'h04;  5'b01111: return 8'h05;  5'b10000: return 8'h06;
      5'b00111: return 8'h07;  5'b01001: return 8'h08;  5'b01010: return 8'h09;
      5'b01011: return 8'h0A;  5'b10001: return 8'h0B;  5'b10010: return 8'h0C;
      default:  return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ph_t mk(input logic [17:0] s, input logic [3:0] sel, input logic [7:0] alu,
                             input bit chk, input bit mem, input int phase);
    ph_t p;
    p.strb = s; p.sel = sel; p.alu = alu; p.alu_chk = chk; p.mem = mem; p.phase = phase;
    return p;
  endfunction

  // Runs one instruction starting at a negedge where T0 is expected; checks every cycle.
  task automatic run_instr(input logic [31:0] ir_v, input int wait_n, input bit drop_t3,
                           input bit abort_t4);
    ph_t q[$];
    logic [4:0] opc = ir_v[31:27];
    logic [3:0] ra = ir_v[26:23], rb = ir_v[22:19], rc = ir_v[18:15];
    int k = kind_of(opc);
    logic [7:0] code = alu_of(opc);
    logic [17:0] fin;
    q.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 4'd0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 0));
    for (int w = 0; w < wait_n; w++)
      q.push_back(mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 4'd0, 8'h00, 1'b1, 1'b0, 1));
    q.push_back(mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 4'd0, 8'h00, 1'b1, 1'b1, 1));
    q.push_back(mk(S_MDROUT | S_IRIN, 4'd0, 8'h00, 1'b1, 1'($urandom_range(0, 1)), 2));
    if (k == K_BIN || k == K_WIDE)
      q.push_back(mk(S_ROUT | S_YIN, rb, 8'h00, 1'b1, 1'($urandom_range(0, 1)), 3));
    else if (k == K_UN)
      q.push_back(mk(S_ROUT | S_ZIN, rb, code, 1'b1, 1'($urandom_range(0, 1)), 3));
    else
      q.push_back(mk(18'h0, 4'd0, 8'h00, 1'b1, 1'($urandom_range(0, 1)), 3));
    if (k == K_BIN || k == K_WIDE)
      q.push_back(mk(S_ROUT | S_ZIN, rc, code, 1'b1, 1'($urandom_range(0, 1)), 4));
    if (k == K_WIDE) begin
      q.push_back(mk(S_ZLOW | S_LOIN, 4'd0, 8'h00, 1'b1, 1'($urandom_range(0, 1)), 5));
      q.push_back(mk(S_ZHIGH | S_HIIN, 4'd0, 8'h00, 1'b1, 1'($urandom_range(0, 1)), 6));
    end else if (k == K_BIN || k == K_UN) begin
      q.push_back(mk(S_ZLOW | S_RIN, ra, 8'h00, 1'b1, 1'($urandom_range(0, 1)), 5));
    end
    cs_if.ir = ir_v;
    foreach (q[i]) begin
      cs_if.mem_ready = q[i].mem;
      if (drop_t3 && q[i].phase == 3) cs_if.run = 1'b0;
      check($sformatf("strb_p%0d", q[i].phase), 32'(obs_strb()), 32'(q[i].strb));
      check($sformatf("sel_p%0d", q[i].phase), 32'(cs_if.reg_sel), 32'(q[i].sel));
      if (q[i].alu_chk)
        check($sformatf("alu_p%0d", q[i].phase), 32'(cs_if.ALU_control), 32'(q[i].alu));
      if (abort_t4 && q[i].phase == 4) return;
      @(posedge clock);
      @(negedge clock);
    end
    fin = 18'h0;
    if (k == K_TRAP) fin = S_HALT | S_ILL;
    else begin
      model_cnt++;
      if (k == K_HALT) fin = S_HALT;
    end
    check("count", 32'(cs_if.instr_count), 32'(model_cnt[15:0]));
    check("flags", 32'({cs_if.halted, cs_if.illegal_op}), 32'(fin[1:0]));
  endtask

  // Applies clear_n at a negedge, checks the async reset state, then restarts into T0.
  task automatic do_reset();
    clear_n = 1'b0;
    #1;
    model_cnt = 0;
    check("rst_strb", 32'(obs_strb()), 32'd0);
    check("rst_count", 32'(cs_if.instr_count), 32'd0);
    @(negedge clock);
    cs_if.run = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("idle_strb", 32'(obs_strb()), 32'd0);
    cs_if.run = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [4:0] ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01001,
                           5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11010};

  initial begin
    clear_n = 1'b1;
    cs_if.run = 1'b0;
    cs_if.mem_ready = 1'b0;
    cs_if.ir = 32'h0;
    @(negedge clock);
    do_reset();
    // AND R4,R5,R7 with memory always ready, then a 3-cycle memory stall, then MUL
    run_instr(32'h2A2B8000, 0, 1'b0, 1'b0);
    run_instr({5'b00100, 4'd1, 4'd2, 4'd3, 15'h0}, 3, 1'b0, 1'b0);
    run_instr({5'b01111, 4'd9, 4'd10, 4'd11, 15'h1234}, 0, 1'b0, 1'b0);
    for (int n = 0; n < 30; n++)
      run_instr({ops[$urandom_range(0, 12)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 15'($urandom)}, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    // run dropped at T3: instruction finishes, then sequencer idles
    run_instr({5'b00011, 4'd2, 4'd3, 4'd4, 15'h0}, 1, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      check("idle_after_drop", 32'(obs_strb()), 32'd0);
      @(posedge clock);
      @(negedge clock);
    end
    check("count_after_drop", 32'(cs_if.instr_count), 32'(model_cnt[15:0]));
    cs_if.run = 1'b1;
    @(posedge clock);
    @(negedge clock);
    // clear_n pulsed mid-T4, then restart from T0
    run_instr({5'b00110, 4'd6, 4'd7, 4'd8, 15'h0}, 0, 1'b0, 1'b1);
    do_reset();
    run_instr({5'b01011, 4'd15, 4'd0, 4'd14, 15'h0}, 2, 1'b0, 1'b0);
    // undefined opcode: trap or counted NOP depending on build
    run_instr({5'b11111, 4'd1, 4'd1, 4'd1, 15'h0}, 0, 1'b0, 1'b0);
    do_reset();
    run_instr({5'b10001, 4'd3, 4'd12, 4'd0, 15'h0}, 0, 1'b0, 1'b0);
    run_instr({5'b11011, 4'd0, 4'd0, 4'd0, 15'h0}, 0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      check("halt_hold", 32'(obs_strb()), 32'(S_HALT));
      check("halt_count", 32'(cs_if.instr_count), 32'(model_cnt[15:0]));
      @(posedge clock);
      @(negedge clock);
    end
    clear_n = 1'b0;
    #1;
    check("halt_clear_strb", 32'(obs_strb()), 32'd0);
    check("halt_clear_count", 32'(cs_if.instr_count), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
